// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit accumulator ALU and its dot-product controller:
// opcodes, data width and controller state encoding.
package alu_pkg;

    localparam int DW = 16;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;
    localparam logic [2:0] ALU_DEC = 3'd4;
    localparam logic [2:0] ALU_CLR = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_S,
        ST_CLR_X,
        ST_FETCH,
        ST_MUL_S,
        ST_MUL_X,
        ST_ADD_S,
        ST_ADD_X,
        ST_DEC_S,
        ST_DEC_X,
        ST_DONE
    } ctrl_state_e;

    // Only the *_X half of each operation carries a command; everything else is NOP,
    // which guarantees a NOP between any two commands.
    function automatic logic [2:0] state_op(input ctrl_state_e s);
        case (s)
            ST_CLR_X: return ALU_CLR;
            ST_MUL_X: return ALU_MUL;
            ST_ADD_X: return ALU_ADD;
            ST_DEC_X: return ALU_DEC;
            default:  return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_dot_ctrl.sv
// Dot-product sequencer for the accumulator ALU: multiply, accumulate, then
// decrement the loop count through the ALU's own DEC/zero-flag operation.
module alu_dot_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] len,
    input  logic          op_valid,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          op_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [DW-1:0] aluIn1,
    output logic [DW-1:0] aluIn2,
    output logic [2:0]    aluOp,
    input  logic [DW-1:0] aluOut,
    input  logic          z
);

    ctrl_state_e   r_state, w_state_next;
    logic [DW-1:0] r_ac, r_a, r_b, r_prod, r_cnt, r_result;
    logic [DW-1:0] w_ac_next, w_a_next, w_b_next, w_prod_next, w_cnt_next, w_result_next;
    logic [DW-1:0] r_alu_in1, r_alu_in2, w_in1_next, w_in2_next;
    logic [2:0]    r_alu_op, w_op_next;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        w_state_next  = r_state;
        w_ac_next     = r_ac;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_prod_next   = r_prod;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;

        case (r_state)
            ST_IDLE: if (start) begin
                w_cnt_next    = len;
                w_result_next = '0;
                w_state_next  = ST_CLR_S;
            end
            ST_CLR_S: w_state_next = ST_CLR_X;
            ST_CLR_X: begin
                w_ac_next    = aluOut;
                w_state_next = (r_cnt == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: if (op_valid) begin
                w_a_next     = op_a;
                w_b_next     = op_b;
                w_state_next = ST_MUL_S;
            end
            ST_MUL_S: w_state_next = ST_MUL_X;
            ST_MUL_X: begin
                w_prod_next  = aluOut;
                w_state_next = ST_ADD_S;
            end
            ST_ADD_S: w_state_next = ST_ADD_X;
            ST_ADD_X: begin
                w_ac_next    = aluOut;
                w_state_next = ST_DEC_S;
            end
            ST_DEC_S: w_state_next = ST_DEC_X;
            ST_DEC_X: begin
                w_cnt_next   = aluOut;
                w_state_next = z ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_result_next = r_ac;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // NOTE: ALU command/operands are registered from the *next* state and next register
        // values, so they line up with the state they belong to without a cycle of lag.
        w_in1_next = r_alu_in1;
        w_in2_next = r_alu_in2;
        case (w_state_next)
            ST_CLR_S, ST_CLR_X: begin w_in1_next = '0;        w_in2_next = '0;          end
            ST_MUL_S, ST_MUL_X: begin w_in1_next = w_a_next;  w_in2_next = w_b_next;    end
            ST_ADD_S, ST_ADD_X: begin w_in1_next = w_ac_next; w_in2_next = w_prod_next; end
            ST_DEC_S, ST_DEC_X: begin w_in1_next = w_cnt_next; w_in2_next = '0;         end
            default: ;
        endcase
        w_op_next = state_op(w_state_next);
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ac      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_alu_op  <= ALU_NOP;
        end else begin
            r_state   <= w_state_next;
            r_ac      <= w_ac_next;
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_prod    <= w_prod_next;
            r_cnt     <= w_cnt_next;
            r_result  <= w_result_next;
            r_alu_in1 <= w_in1_next;
            r_alu_in2 <= w_in2_next;
            r_alu_op  <= w_op_next;
        end
    end

    assign op_ready = (r_state == ST_FETCH);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign aluIn1   = r_alu_in1;
    assign aluIn2   = r_alu_in2;
    assign aluOp    = r_alu_op;

endmodule

// File: tb/tb_alu_dot_ctrl.sv
// Directed bench for alu_dot_ctrl with a behavioural accumulator ALU and a result scoreboard.
module tb_alu_dot_ctrl;
    import alu_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n, start, op_valid;
    logic [DW-1:0] len, op_a, op_b;
    logic          op_ready, busy, done;
    logic [DW-1:0] result, aluIn1, aluIn2;
    logic [2:0]    aluOp;
    logic [DW-1:0] alu_out = '0;
    logic          alu_z   = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pa[$];
    logic [DW-1:0] pb[$];
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    alu_dot_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .op_valid (op_valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .aluIn1   (aluIn1),
        .aluIn2   (aluIn2),
        .aluOp    (aluOp),
        .aluOut   (alu_out),
        .z        (alu_z)
    );

    // Behavioural ALU: re-evaluates only when the command changes; NOP holds the output.
    always @(aluOp) begin
        case (aluOp)
            ALU_ADD: alu_out = aluIn1 + aluIn2;
            ALU_SUB: alu_out = aluIn1 - aluIn2;
            ALU_MUL: alu_out = aluIn1 * aluIn2;
            ALU_DEC: alu_out = aluIn1 - 16'd1;
            ALU_CLR: alu_out = '0;
            ALU_XOR: alu_out = aluIn1 ^ aluIn2;
            default: ;
        endcase
        alu_z = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Command-interface protocol, sampled 2 time units after each rising edge.
    logic [2:0]    prev_op  = ALU_NOP;
    logic [DW-1:0] prev_in1 = '0;
    logic [DW-1:0] prev_in2 = '0;
    always begin
        @(posedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (prev_op != ALU_NOP) check("op_back_to_back", {29'd0, aluOp}, {29'd0, ALU_NOP});
            if (aluOp != ALU_NOP) begin
                check("in1_stable", {16'd0, aluIn1}, {16'd0, prev_in1});
                check("in2_stable", {16'd0, aluIn2}, {16'd0, prev_in2});
            end
            prev_op = aluOp;
        end else begin
            prev_op = ALU_NOP;
        end
        prev_in1 = aluIn1;
        prev_in2 = aluIn2;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_op_ready"}, {31'd0, op_ready}, 32'd0);
        check({tag, "_result"},   {16'd0, result},   32'd0);
        check({tag, "_aluOp"},    {29'd0, aluOp},    32'd0);
        check({tag, "_aluIn1"},   {16'd0, aluIn1},   32'd0);
        check({tag, "_aluIn2"},   {16'd0, aluIn2},   32'd0);
    endtask

    // One dot product over pa/pb; stall = op_valid-low cycles in the first FETCH,
    // poke_at = cycle after T at which a spurious start is pulsed (0 = none).
    task automatic run_dot(input string tag, input logic [DW-1:0] n, input int stall, input int poke_at);
        logic [DW-1:0] exp_acc, term;
        int cyc, hs, rdy_cycles, idx, stall_left;
        exp_acc = '0;
        for (int i = 0; i < int'(n); i++) begin
            term    = pa[i] * pb[i];
            exp_acc = exp_acc + term;
        end
        sb.push_back(exp_acc);
        hs = 0; rdy_cycles = 0; idx = 0; stall_left = stall;

        @(negedge clk);
        start = 1'b1; len = n; op_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 2000) begin
            start = (cyc == poke_at);
            if (cyc == poke_at) len = 16'd7;
            if (op_ready) begin
                rdy_cycles++;
                if (stall_left > 0) begin
                    op_valid = 1'b0;
                    stall_left--;
                    check({tag, "_stall_aluOp"}, {29'd0, aluOp}, 32'd0);
                end else begin
                    op_valid = 1'b1;
                    op_a     = pa[idx];
                    op_b     = pb[idx];
                    idx++;
                    hs++;
                end
            end else begin
                op_valid = 1'b1;
                op_a     = 16'($urandom());
                op_b     = 16'($urandom());
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; op_valid = 1'b0;
        check({tag, "_done_seen"},  {31'd0, done}, 32'd1);
        check({tag, "_latency"},    cyc, 3 + 7 * int'(n) + stall);
        check({tag, "_handshakes"}, hs, int'(n));
        check({tag, "_ready_cyc"},  rdy_cycles, int'(n) + stall);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_fall"},  {31'd0, busy}, 32'd0);
        check({tag, "_result"},     {16'd0, result}, {16'd0, sb.pop_front()});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        pa = '{16'd2, 16'd4, 16'd1}; pb = '{16'd3, 16'd5, 16'd7};
        run_dot("basic", 16'd3, 0, 0);

        run_dot("empty", 16'd0, 0, 0);

        pa = '{16'd300}; pb = '{16'd300};
        run_dot("wrap", 16'd1, 0, 0);

        pa = '{16'd11, 16'd65535}; pb = '{16'd13, 16'd2};
        run_dot("backpressure", 16'd2, 5, 0);

        pa = '{16'd2, 16'd4, 16'd1}; pb = '{16'd3, 16'd5, 16'd7};
        run_dot("start_busy", 16'd3, 0, 5);

        // Abort a run with reset while the first accumulate is executing.
        @(negedge clk);
        start = 1'b1; len = 16'd2;
        @(negedge clk);
        start = 1'b0; op_valid = 1'b1; op_a = 16'd9; op_b = 16'd9;
        k = 0;
        while (aluOp != ALU_ADD && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_reach_add", {29'd0, aluOp}, {29'd0, ALU_ADD});
        rst_n = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        rst_n = 1'b1;

        pa = '{16'd6}; pb = '{16'd7};
        run_dot("after_rst", 16'd1, 0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
